regfile_sweep: RTL

Parametrised multi-port CHERIoT integer register file, successor to the fixed 4-read/3-write regfile. It adds configurable read/write port counts and optional write-to-read bypass. It also adds a background revocation sweep engine that walks every tagged register, offers it to an external revocation checker over a valid/ready handshake, and clears its tag on request. It sits in the same place as the existing regfile, between the issue stage (reads) and the writeback/load pipes (writes).

---
 rtl/regfile_sweep.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regfile_sweep.sv
// Multi-port CHERIoT integer register file with optional write bypass and a background
// revocation sweep engine that offers tagged registers to an external checker.
module regfile_sweep #(
    parameter int unsigned NRegs     = 32,
    parameter int unsigned RegW      = 33,
    parameter int unsigned NRdPorts  = 4,
    parameter int unsigned NWrPorts  = 3,
    parameter int unsigned WrBypass  = 0,
    parameter int unsigned CHERIoTEn = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NRdPorts*5-1:0]      raddr_i,
    output logic [NRdPorts*RegW-1:0]   rdata_o,
    input  logic [NWrPorts*5-1:0]      waddr_i,
    input  logic [NWrPorts*RegW-1:0]   wdata_i,
    input  logic [NWrPorts-1:0]        we_i,
    input  logic                       trvk_en_i,
    input  logic                       trvk_clrtag_i,
    input  logic [4:0]                 trvk_addr_i,
    input  logic                       sweep_req_i,
    input  logic                       sweep_abort_i,
    output logic                       sweep_valid_o,
    input  logic                       sweep_ready_i,
    input  logic                       sweep_clr_i,
    output logic [4:0]                 sweep_addr_o,
    output logic [RegW-1:0]            sweep_data_o,
    output logic                       sweep_busy_o,
    output logic                       sweep_done_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic CapEn = (CHERIoTEn != 0);
    localparam logic BypEn = (WrBypass != 0);

    logic [RegW-1:0] rf_q    [1:NRegs-1];
    logic [RegW-1:0] rf_d    [1:NRegs-1];
    logic [RegW-1:0] byp_val [1:NRegs-1];
    logic [NRegs-1:1] byp_hit;

    logic [1:0]      state_q, state_d;
    logic [4:0]      ptr_q, ptr_d;
    logic [RegW-1:0] cur_data;
    logic            cur_tag;
    logic            offer;
    logic            sweep_clr;
    logic            trvk_act;

    always_comb begin
        cur_data = '0;
        for (int i = 1; i < int'(NRegs); i++) begin
            if (ptr_q == 5'(i)) cur_data = rf_q[i];
        end
    end

    assign cur_tag   = cur_data[RegW-1];
    assign offer     = CapEn && (state_q == StScan) && cur_tag;
    // Abort wins over a same-cycle handshake, so no clear may leak through.
    assign sweep_clr = offer & sweep_ready_i & sweep_clr_i & ~sweep_abort_i;
    assign trvk_act  = CapEn & trvk_en_i & trvk_clrtag_i;

    always_comb begin
        logic            hit;
        logic [RegW-1:0] val;
        for (int i = 1; i < int'(NRegs); i++) begin
            hit = 1'b0;
            val = rf_q[i];
            for (int k = 0; k < int'(NWrPorts); k++) begin
                if (we_i[k] && (waddr_i[5*k +: 5] == 5'(i))) begin
                    hit = 1'b1;
                    val = wdata_i[RegW*k +: RegW];
                end
            end
            // trvk clear masks the tag even under a write; a sweep clear yields to writes.
            if (trvk_act && (trvk_addr_i == 5'(i))) val[RegW-1] = 1'b0;
            byp_hit[i] = hit;
            byp_val[i] = val;
            rf_d[i]    = val;
            if (!hit && sweep_clr && (ptr_q == 5'(i))) rf_d[i][RegW-1] = 1'b0;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < int'(NRdPorts); p++) begin
            for (int i = 1; i < int'(NRegs); i++) begin
                if (raddr_i[5*p +: 5] == 5'(i)) begin
                    rdata_o[RegW*p +: RegW] = (BypEn && byp_hit[i]) ? byp_val[i] : rf_q[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (sweep_req_i && CapEn) begin
                    state_d = StScan;
                    ptr_d   = 5'd1;
                end
            end
            StScan: begin
                if (sweep_abort_i) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else if (!cur_tag || sweep_ready_i) begin
                    if (ptr_q == 5'(NRegs - 1)) state_d = StDone;
                    else                        ptr_d   = ptr_q + 5'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                ptr_d   = '0;
            end
            default: begin
                state_d = StIdle;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            for (int i = 1; i < int'(NRegs); i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            for (int i = 1; i < int'(NRegs); i++) rf_q[i] <= rf_d[i];
        end
    end

    assign sweep_valid_o = offer;
    assign sweep_addr_o  = ptr_q;
    assign sweep_data_o  = cur_data;
    assign sweep_busy_o  = (state_q != StIdle);
    assign sweep_done_o  = (state_q == StDone) && !sweep_abort_i;

endmodule
